// File: rtl/lighthouse_frame_scheduler.sv
// rtl/lighthouse_frame_scheduler.sv - round-robin lighthouse frame sequencer for the SPI frame controller
module lighthouse_frame_scheduler #(
    parameter int NUMBER_OF_SENSORS = 8,
    parameter int GAP_CYCLES        = 1024,
    parameter int TIMEOUT_CYCLES    = 65536
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [NUMBER_OF_SENSORS-1:0] sync_i,
    input  logic                         trigger_me,
    input  logic                         ss_n_i,
    output logic [3:0]                   frame_sel_o,
    output logic                         data_ready_o,
    output logic                         busy_o,
    output logic [15:0]                  frames_sent_o,
    output logic [7:0]                   timeout_count_o
);

    localparam int NF   = (NUMBER_OF_SENSORS + 7) / 8;
    localparam int TMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        GAP       = 3'd4
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [NF-1:0]   pending;
    logic [NF-1:0]   sync_hit;
    logic [NF-1:0]   pending_set;
    logic [NF-1:0]   pending_clr;
    logic [NF-1:0]   rot;
    logic [NF*8-1:0] sync_pad;
    logic [3:0]      last;
    logic [3:0]      pick;
    logic            pick_valid;
    logic [TW-1:0]   timer;
    logic            ss_prev;
    logic            ss_rise;
    logic            timed_out;
    logic            gap_done;
    logic            select;
    logic            complete;
    logic            abort;
    logic            data_ready_d;
    logic            busy_d;
    int              idx;

    assign ss_rise   = !ss_prev && ss_n_i;
    assign timed_out = (timer == TW'(TIMEOUT_CYCLES - 2));
    assign gap_done  = (timer == TW'(GAP_CYCLES - 1));
    assign select    = (state == IDLE) && enable && pick_valid;
    assign complete  = (state == WAIT_HIGH) && ss_rise;
    assign abort     = timed_out && ((state == WAIT_LOW) || ((state == WAIT_HIGH) && !ss_rise));

    // Widen the sensor vector to whole frames so missing sensors read as zero
    always_comb begin
        sync_pad = '0;
        sync_pad[NUMBER_OF_SENSORS-1:0] = sync_i;
    end

    // One new-data request per frame: any of its eight sensors pulsed
    always_comb begin
        sync_hit = '0;
        for (int f = 0; f < NF; f++) begin
            sync_hit[f] = |sync_pad[8*f +: 8];
        end
    end

    // Round-robin search starting just after the last served frame; descending loop keeps the nearest hit
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        idx        = 0;
        rot        = '0;
        for (int i = NF; i >= 1; i--) begin
            idx = (int'(last) + i) % NF;
            rot = pending >> idx;
            if (rot[0]) begin
                pick       = 4'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    // Pending set sources (sync, debug trigger, timeout retry) and the selection clear
    always_comb begin
        pending_set = sync_hit | {NF{trigger_me}};
        pending_clr = '0;
        if (abort) begin
            pending_set = pending_set | (NF'(1) << frame_sel_o);
        end
        if (select) begin
            pending_clr = NF'(1) << pick;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; in WAIT_HIGH a completing edge beats a simultaneous timeout
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (select) next_state = ISSUE;
            ISSUE:     next_state = WAIT_LOW;
            WAIT_LOW:  begin
                if (abort) next_state = GAP;
                else if (!ss_n_i) next_state = WAIT_HIGH;
            end
            WAIT_HIGH: if (complete || abort) next_state = GAP;
            GAP:       if (gap_done) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Output decode, registered below so no input reaches an output combinationally
    always_comb begin
        data_ready_d = (state == ISSUE);
        busy_d       = (next_state != IDLE);
    end

    // Datapath: pending flags, frame select, counters, timer and slave-select history
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending         <= '0;
            last            <= 4'(NF - 1);
            frame_sel_o     <= '0;
            data_ready_o    <= 1'b0;
            busy_o          <= 1'b0;
            frames_sent_o   <= '0;
            timeout_count_o <= '0;
            ss_prev         <= 1'b1;
            timer           <= '0;
        end else begin
            ss_prev      <= ss_n_i;
            pending      <= (pending & ~pending_clr) | pending_set;
            data_ready_o <= data_ready_d;
            busy_o       <= busy_d;
            if (select) begin
                frame_sel_o <= pick;
                last        <= pick;
            end
            if (complete) begin
                frames_sent_o <= frames_sent_o + 16'd1;
            end
            if (abort && (timeout_count_o != 8'hFF)) begin
                timeout_count_o <= timeout_count_o + 8'd1;
            end
            // Timer restarts on each state entry, but keeps running across WAIT_LOW -> WAIT_HIGH
            if ((state == IDLE) || (state == ISSUE) ||
                ((next_state != state) && !((state == WAIT_LOW) && (next_state == WAIT_HIGH)))) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_lighthouse_frame_scheduler.sv
// tb/tb_lighthouse_frame_scheduler.sv - directed self-checking bench for lighthouse_frame_scheduler
module tb_lighthouse_frame_scheduler;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [23:0] sync_i;
    logic        trigger_me;
    logic        ss_n_i;
    logic [3:0]  frame_sel_o;
    logic        data_ready_o;
    logic        busy_o;
    logic [15:0] frames_sent_o;
    logic [7:0]  timeout_count_o;

    int checks;
    int failures;

    lighthouse_frame_scheduler #(
        .NUMBER_OF_SENSORS(24),
        .GAP_CYCLES(16),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .sync_i(sync_i),
        .trigger_me(trigger_me),
        .ss_n_i(ss_n_i),
        .frame_sel_o(frame_sel_o),
        .data_ready_o(data_ready_o),
        .busy_o(busy_o),
        .frames_sent_o(frames_sent_o),
        .timeout_count_o(timeout_count_o)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic quiet(input int n, output bit saw);
        saw = 1'b0;
        repeat (n) begin
            @(negedge clock);
            if (data_ready_o) saw = 1'b1;
        end
    endtask

    // Wait for a transmit request, act as SPI master (5 cycles, then ss_n low), wait for return to IDLE
    task automatic serve(input int low_len, input logic [23:0] pulse,
                         output bit got, output logic [3:0] sel, output bit done);
        got  = 1'b0;
        done = 1'b0;
        sel  = '0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clock);
            if (data_ready_o) begin
                got = 1'b1;
                sel = frame_sel_o;
            end
        end
        if (got) begin
            repeat (5) @(negedge clock);
            ss_n_i = 1'b0;
            sync_i = pulse;
            @(negedge clock);
            sync_i = '0;
            repeat (low_len - 1) @(negedge clock);
            ss_n_i = 1'b1;
            for (int i = 0; i < 100 && !done; i++) begin
                @(negedge clock);
                if (!busy_o) done = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({data_ready_o, busy_o, frame_sel_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got dr=%b busy=%b sel=%0d expected 0 0 0", data_ready_o, busy_o, frame_sel_o);
        end
        checks++;
        if ({frames_sent_o, timeout_count_o} !== 24'h0) begin
            failures++;
            $display("FAIL reset_counters: got sent=%0d to=%0d expected 0 0", frames_sent_o, timeout_count_o);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_single_frame();
        sync_i = 24'h000008;
        @(negedge clock);
        sync_i = '0;
        checks++;
        if ({busy_o, data_ready_o} !== 2'b00) begin
            failures++;
            $display("FAIL single_k: got busy=%b dr=%b expected 0 0", busy_o, data_ready_o);
        end
        @(negedge clock);
        checks++;
        if ({busy_o, data_ready_o, frame_sel_o} !== {1'b1, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL single_select: got busy=%b dr=%b sel=%0d expected 1 0 0", busy_o, data_ready_o, frame_sel_o);
        end
        @(negedge clock);
        checks++;
        if (data_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL single_dr_high: got %b expected 1", data_ready_o);
        end
        @(negedge clock);
        checks++;
        if (data_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL single_dr_one_cycle: got %b expected 0", data_ready_o);
        end
        repeat (4) @(negedge clock);
        ss_n_i = 1'b0;
        repeat (40) @(negedge clock);
        ss_n_i = 1'b1;
        @(negedge clock);
        checks++;
        if ({frames_sent_o, busy_o} !== {16'd1, 1'b1}) begin
            failures++;
            $display("FAIL single_done: got sent=%0d busy=%b expected 1 1", frames_sent_o, busy_o);
        end
        repeat (15) @(negedge clock);
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL single_gap_end: got busy=%b expected 1", busy_o);
        end
        @(negedge clock);
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: got busy=%b expected 0", busy_o);
        end
    endtask

    task automatic test_round_robin();
        bit got, done, saw;
        logic [3:0] sel;
        logic [3:0] exp_order [4] = '{4'd0, 4'd1, 4'd2, 4'd0};
        do_reset();
        trigger_me = 1'b1;
        @(negedge clock);
        trigger_me = 1'b0;
        for (int n = 0; n < 4; n++) begin
            serve(40, (n == 1) ? 24'h100001 : 24'h0, got, sel, done);
            checks++;
            if ({got, done, sel} !== {1'b1, 1'b1, exp_order[n]}) begin
                failures++;
                $display("FAIL rr_frame%0d: got got=%b done=%b sel=%0d expected 1 1 %0d", n, got, done, sel, exp_order[n]);
            end
        end
        quiet(60, saw);
        checks++;
        if ({saw, frames_sent_o} !== {1'b0, 16'd4}) begin
            failures++;
            $display("FAIL rr_drain: got extra=%b sent=%0d expected 0 4", saw, frames_sent_o);
        end
    endtask

    task automatic test_collision();
        bit got, done, saw;
        logic [3:0] sel;
        sync_i = 24'h000001;
        @(negedge clock);
        sync_i = 24'h000002;
        @(negedge clock);
        sync_i = '0;
        checks++;
        if ({busy_o, frame_sel_o} !== {1'b1, 4'd0}) begin
            failures++;
            $display("FAIL coll_select: got busy=%b sel=%0d expected 1 0", busy_o, frame_sel_o);
        end
        for (int n = 0; n < 2; n++) begin
            serve(40, 24'h0, got, sel, done);
            checks++;
            if ({got, done, sel} !== {1'b1, 1'b1, 4'd0}) begin
                failures++;
                $display("FAIL coll_tx%0d: got got=%b done=%b sel=%0d expected 1 1 0", n, got, done, sel);
            end
        end
        quiet(60, saw);
        checks++;
        if ({saw, frames_sent_o} !== {1'b0, 16'd6}) begin
            failures++;
            $display("FAIL coll_drain: got extra=%b sent=%0d expected 0 6", saw, frames_sent_o);
        end
    endtask

    task automatic test_timeout();
        bit got, done;
        logic [3:0] sel;
        sync_i = 24'h000100;
        @(negedge clock);
        sync_i = '0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if ({data_ready_o, frame_sel_o} !== {1'b1, 4'd1}) begin
            failures++;
            $display("FAIL to_issue: got dr=%b sel=%0d expected 1 1", data_ready_o, frame_sel_o);
        end
        repeat (98) @(negedge clock);
        checks++;
        if ({timeout_count_o, busy_o} !== {8'd0, 1'b1}) begin
            failures++;
            $display("FAIL to_before: got to=%0d busy=%b expected 0 1", timeout_count_o, busy_o);
        end
        @(negedge clock);
        checks++;
        if ({timeout_count_o, frames_sent_o} !== {8'd1, 16'd6}) begin
            failures++;
            $display("FAIL to_abort: got to=%0d sent=%0d expected 1 6", timeout_count_o, frames_sent_o);
        end
        for (int a = 2; a <= 300; a++) begin
            got  = 1'b0;
            done = 1'b0;
            sel  = '0;
            for (int i = 0; i < 300 && !got; i++) begin
                @(negedge clock);
                if (data_ready_o) begin
                    got = 1'b1;
                    sel = frame_sel_o;
                end
            end
            for (int i = 0; i < 300 && got && !done; i++) begin
                @(negedge clock);
                if (!busy_o) done = 1'b1;
            end
            if (!got || !done) begin
                checks++;
                failures++;
                $display("FAIL to_retry_stall: got got=%b done=%b at attempt %0d expected 1 1", got, done, a);
                break;
            end
            if (a == 2) begin
                checks++;
                if ({sel, timeout_count_o} !== {4'd1, 8'd2}) begin
                    failures++;
                    $display("FAIL to_retry: got sel=%0d to=%0d expected 1 2", sel, timeout_count_o);
                end
            end
            if (a == 255) begin
                checks++;
                if (timeout_count_o !== 8'd255) begin
                    failures++;
                    $display("FAIL to_255: got %0d expected 255", timeout_count_o);
                end
            end
        end
        checks++;
        if ({timeout_count_o, frames_sent_o} !== {8'd255, 16'd6}) begin
            failures++;
            $display("FAIL to_saturate: got to=%0d sent=%0d expected 255 6", timeout_count_o, frames_sent_o);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit got, saw;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clock);
            if (data_ready_o) got = 1'b1;
        end
        repeat (3) @(negedge clock);
        ss_n_i = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({got, busy_o} !== 2'b11) begin
            failures++;
            $display("FAIL rst_setup: got got=%b busy=%b expected 1 1", got, busy_o);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy_o, data_ready_o, frame_sel_o, frames_sent_o, timeout_count_o} !== 30'h0) begin
            failures++;
            $display("FAIL rst_async: got busy=%b dr=%b sel=%0d sent=%0d to=%0d expected all 0",
                     busy_o, data_ready_o, frame_sel_o, frames_sent_o, timeout_count_o);
        end
        repeat (2) @(negedge clock);
        ss_n_i  = 1'b1;
        reset_n = 1'b1;
        quiet(60, saw);
        checks++;
        if ({saw, busy_o} !== 2'b00) begin
            failures++;
            $display("FAIL rst_discard: got dr_seen=%b busy=%b expected 0 0", saw, busy_o);
        end
    endtask

    task automatic test_enable();
        bit got, done, saw;
        logic [3:0] sel;
        enable = 1'b0;
        sync_i = 24'h010000;
        @(negedge clock);
        sync_i = '0;
        quiet(20, saw);
        checks++;
        if ({saw, busy_o} !== 2'b00) begin
            failures++;
            $display("FAIL en_blocked: got dr_seen=%b busy=%b expected 0 0", saw, busy_o);
        end
        enable = 1'b1;
        @(negedge clock);
        checks++;
        if ({busy_o, frame_sel_o} !== {1'b1, 4'd2}) begin
            failures++;
            $display("FAIL en_select: got busy=%b sel=%0d expected 1 2", busy_o, frame_sel_o);
        end
        enable = 1'b0;
        serve(40, 24'h000001, got, sel, done);
        checks++;
        if ({got, done, sel, frames_sent_o} !== {1'b1, 1'b1, 4'd2, 16'd1}) begin
            failures++;
            $display("FAIL en_inflight: got got=%b done=%b sel=%0d sent=%0d expected 1 1 2 1", got, done, sel, frames_sent_o);
        end
        quiet(30, saw);
        checks++;
        if ({saw, busy_o} !== 2'b00) begin
            failures++;
            $display("FAIL en_hold: got dr_seen=%b busy=%b expected 0 0", saw, busy_o);
        end
        enable = 1'b1;
        serve(40, 24'h0, got, sel, done);
        checks++;
        if ({got, done, sel, frames_sent_o} !== {1'b1, 1'b1, 4'd0, 16'd2}) begin
            failures++;
            $display("FAIL en_resume: got got=%b done=%b sel=%0d sent=%0d expected 1 1 0 2", got, done, sel, frames_sent_o);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        enable     = 1'b1;
        sync_i     = '0;
        trigger_me = 1'b0;
        ss_n_i     = 1'b1;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_collision();
        test_timeout();
        test_reset_mid_frame();
        test_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
